// File: rtl/host_write_buffer_if.sv
// host_write_buffer_if
//   Bundles the host write channel and the controller read channel of the
//   host write buffer.
//   Host write channel : host_valid, host_ready, host_addr, host_data
//   Controller channel : buffer_empty, buffer_read_enable, buffer_addr,
//                        buffer_data, buffer_count
//   Status             : underflow (sticky), clear_flags
//   master : the host/controller side that drives requests and pops
//   slave  : the buffer itself
interface host_write_buffer_if #(
  parameter int BUFFER_LENGTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                     host_valid;
  logic                     host_ready;
  logic [BUFFER_LENGTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0]    host_data;
  logic                     buffer_empty;
  logic                     buffer_read_enable;
  logic [BUFFER_LENGTH-1:0] buffer_addr;
  logic [DATA_WIDTH-1:0]    buffer_data;
  logic [CW-1:0]            buffer_count;
  logic                     underflow;
  logic                     clear_flags;

  modport master (
    output host_valid, host_addr, host_data, buffer_read_enable, clear_flags,
    input  host_ready, buffer_empty, buffer_addr, buffer_data, buffer_count,
           underflow
  );

  modport slave (
    input  host_valid, host_addr, host_data, buffer_read_enable, clear_flags,
    output host_ready, buffer_empty, buffer_addr, buffer_data, buffer_count,
           underflow
  );
endinterface

// File: rtl/host_write_buffer.sv
// host_write_buffer
//   Upstream stage of the NN accelerator controller. Stores host write
//   transactions (address + data) in a FIFO and presents the head entry
//   first-word-fall-through from registered outputs.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : host_write_buffer_if.slave (host write channel, controller pop
//           channel, buffer_count, sticky underflow with clear_flags)
//
//   state      | meaning
//   HEAD_EMPTY | no entry stored; head registers hold their last value
//   HEAD_VALID | head registers hold a copy of the entry at rd_ptr
module host_write_buffer #(
  parameter int BUFFER_LENGTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16
) (
  input  logic                clk,
  input  logic                reset,
  host_write_buffer_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int EW = BUFFER_LENGTH + DATA_WIDTH;

  typedef enum logic {
    HEAD_EMPTY = 1'b0,
    HEAD_VALID = 1'b1
  } head_state_e;

  logic [EW-1:0] mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_d;
  head_state_e   state_q, state_d;
  logic [EW-1:0] head_q, head_d;
  logic          underflow_q, underflow_d;

  logic          full;
  logic          wr_en;
  logic          pop;
  logic [EW-1:0] next_entry;

  always_comb begin
    full     = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) &&
               (wr_ptr_q[IW] != rd_ptr_q[IW]);
    wr_en    = bus.host_valid & ~full;
    pop      = bus.buffer_read_enable & (state_q == HEAD_VALID);
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = wr_ptr_d - rd_ptr_d;
    // The entry that becomes the head is either already in storage or is
    // the one being written this cycle (head empty, or last entry popped).
    if (rd_ptr_d == wr_ptr_q) begin
      next_entry = {bus.host_addr, bus.host_data};
    end else begin
      next_entry = mem_q[rd_ptr_d[IW-1:0]];
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    case (state_q)
      HEAD_EMPTY: begin
        if (count_d != '0) begin
          state_d = HEAD_VALID;
          head_d  = next_entry;
        end
      end
      HEAD_VALID: begin
        if (pop) begin
          if (count_d == '0) begin
            state_d = HEAD_EMPTY;
          end else begin
            head_d  = next_entry;
          end
        end
      end
      default: state_d = HEAD_EMPTY;
    endcase
  end

  always_comb begin
    underflow_d = underflow_q;
    if (bus.clear_flags) begin
      underflow_d = 1'b0;
    end else if (bus.buffer_read_enable && (state_q == HEAD_EMPTY)) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= HEAD_EMPTY;
      head_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      head_q      <= head_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[IW-1:0]] <= {bus.host_addr, bus.host_data};
    end
  end

  assign bus.host_ready   = ~full;
  assign bus.buffer_empty = (state_q == HEAD_EMPTY);
  assign bus.buffer_addr  = head_q[EW-1:DATA_WIDTH];
  assign bus.buffer_data  = head_q[DATA_WIDTH-1:0];
  assign bus.buffer_count = wr_ptr_q - rd_ptr_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_host_write_buffer.sv
// tb_host_write_buffer
//   Self-checking bench for host_write_buffer. A queue-based model of the
//   FIFO contents is compared against the DUT on every falling edge, and
//   directed scenarios add literal expectations.
module tb_host_write_buffer;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  host_write_buffer_if #(.BUFFER_LENGTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  host_write_buffer #(.BUFFER_LENGTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW+DW-1:0] mq[$];
  logic [AW+DW-1:0] m_head;
  logic             m_uf;
  bit               chk_en;
  bit               log_pops;
  logic [DW-1:0]    dut_pops[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("empty", 64'(bus.buffer_empty), 64'(mq.size() == 0));
      check("count", 64'(bus.buffer_count), 64'(mq.size()));
      check("ready", 64'(bus.host_ready),   64'(mq.size() < DEPTH));
      check("addr",  64'(bus.buffer_addr),  64'(m_head[AW+DW-1:DW]));
      check("data",  64'(bus.buffer_data),  64'(m_head[DW-1:0]));
      check("uflow", 64'(bus.underflow),    64'(m_uf));
    end
  end

  // One clock cycle of stimulus; the model advances right after the edge.
  task automatic cyc(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic re, input logic clr);
    logic acc, pp;
    bus.host_valid         = v;
    bus.host_addr          = a;
    bus.host_data          = d;
    bus.buffer_read_enable = re;
    bus.clear_flags        = clr;
    acc = v && (mq.size() < DEPTH);
    pp  = re && (mq.size() > 0);
    if (pp && log_pops) dut_pops.push_back(bus.buffer_data);
    @(posedge clk);
    if (clr) m_uf = 1'b0;
    else if (re && mq.size() == 0) m_uf = 1'b1;
    if (pp) void'(mq.pop_front());
    if (acc) mq.push_back({a, d});
    if (mq.size() > 0) m_head = mq[0];
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_head = '0;
    m_uf   = 1'b0;
  endtask

  initial begin
    bus.host_valid         = 1'b0;
    bus.host_addr          = '0;
    bus.host_data          = '0;
    bus.buffer_read_enable = 1'b0;
    bus.clear_flags        = 1'b0;
    reset    = 1'b1;
    chk_en   = 1'b0;
    log_pops = 1'b0;
    model_reset();

    #12;
    check("rst_empty", 64'(bus.buffer_empty), 64'd1);
    check("rst_count", 64'(bus.buffer_count), 64'd0);
    check("rst_ready", 64'(bus.host_ready),   64'd1);
    check("rst_addr",  64'(bus.buffer_addr),  64'd0);
    check("rst_data",  64'(bus.buffer_data),  64'd0);
    check("rst_uflow", 64'(bus.underflow),    64'd0);
    @(posedge clk); #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    idle();

    // T2: single write into empty FIFO, visible next cycle
    cyc(1'b1, 16'h0010, 32'hCAFE0001, 1'b0, 1'b0);
    check("t2_empty", 64'(bus.buffer_empty), 64'd0);
    check("t2_addr",  64'(bus.buffer_addr),  64'h0010);
    check("t2_data",  64'(bus.buffer_data),  64'hCAFE0001);

    // T1: reset mid-stream with 5 entries stored
    for (int i = 1; i < 5; i++) cyc(1'b1, 16'(16'h0100 + i), 32'(i), 1'b0, 1'b0);
    check("t1_count5", 64'(bus.buffer_count), 64'd5);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t1_in_empty", 64'(bus.buffer_empty), 64'd1);
    check("t1_in_count", 64'(bus.buffer_count), 64'd0);
    check("t1_in_ready", 64'(bus.host_ready),   64'd1);
    check("t1_in_addr",  64'(bus.buffer_addr),  64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    idle();
    check("t1_out_empty", 64'(bus.buffer_empty), 64'd1);
    check("t1_out_count", 64'(bus.buffer_count), 64'd0);
    check("t1_out_addr",  64'(bus.buffer_addr),  64'd0);

    // T3: fill to full, 17th write held until one pop frees a slot
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 16'(16'h1000 + i), 32'(i), 1'b0, 1'b0);
    check("t3_ready_full", 64'(bus.host_ready),   64'd0);
    check("t3_count_full", 64'(bus.buffer_count), 64'd16);
    cyc(1'b1, 16'h2000, 32'hDEAD0017, 1'b0, 1'b0);
    check("t3_held_count", 64'(bus.buffer_count), 64'd16);
    cyc(1'b1, 16'h2000, 32'hDEAD0017, 1'b1, 1'b0);
    check("t3_pop_count", 64'(bus.buffer_count), 64'd15);
    check("t3_pop_ready", 64'(bus.host_ready),   64'd1);
    check("t3_pop_head",  64'(bus.buffer_data),  64'd1);
    cyc(1'b1, 16'h2000, 32'hDEAD0017, 1'b0, 1'b0);
    check("t3_acc_count", 64'(bus.buffer_count), 64'd16);
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("t3_drained", 64'(bus.buffer_empty), 64'd1);
    check("t3_last",    64'(bus.buffer_data),  64'hDEAD0017);

    // T4: random stream of 40 writes with random pops, across the wrap
    begin
      int wi = 0;
      int guard = 0;
      logic v, re;
      log_pops = 1'b1;
      dut_pops.delete();
      while ((wi < 40 || mq.size() > 0) && guard < 3000) begin
        v  = (wi < 40) && ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 3) < ((guard < 60) ? 1 : 3));
        if (v && mq.size() < DEPTH) begin
          cyc(1'b1, 16'($urandom), 32'(wi), re, 1'b0);
          wi++;
        end else begin
          cyc(v, 16'($urandom), 32'(wi), re, 1'b0);
        end
        guard++;
      end
      log_pops = 1'b0;
      check("t4_timeout", 64'(guard < 3000), 64'd1);
      check("t4_npops", 64'(dut_pops.size()), 64'd40);
      for (int i = 0; i < 40 && i < dut_pops.size(); i++)
        check("t4_order", 64'(dut_pops[i]), 64'(i));
      cyc(1'b0, '0, '0, 1'b0, 1'b1);
    end

    // T5: simultaneous write + pop
    cyc(1'b1, 16'h00A1, 32'hA1, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A2, 32'hA2, 1'b0, 1'b0);
    cyc(1'b1, 16'h00A3, 32'hA3, 1'b0, 1'b0);
    check("t5_count3", 64'(bus.buffer_count), 64'd3);
    cyc(1'b1, 16'h00A4, 32'hA4, 1'b1, 1'b0);
    check("t5_wp_count", 64'(bus.buffer_count), 64'd3);
    check("t5_wp_head",  64'(bus.buffer_data),  64'hA2);
    check("t5_wp_addr",  64'(bus.buffer_addr),  64'h00A2);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("t5_empty", 64'(bus.buffer_empty), 64'd1);
    cyc(1'b1, 16'h0055, 32'h55555555, 1'b1, 1'b0);
    check("t5_e_uflow", 64'(bus.underflow),    64'd1);
    check("t5_e_empty", 64'(bus.buffer_empty), 64'd0);
    check("t5_e_data",  64'(bus.buffer_data),  64'h55555555);
    check("t5_e_count", 64'(bus.buffer_count), 64'd1);
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    check("t5_clr", 64'(bus.underflow), 64'd0);

    // T6: sticky underflow, clear wins over a concurrent set
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check("t6_set", 64'(bus.underflow), 64'd1);
    for (int i = 0; i < 10; i++) begin
      idle();
      check("t6_sticky", 64'(bus.underflow), 64'd1);
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b1);
    check("t6_clr_prio", 64'(bus.underflow), 64'd0);
    idle();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
